// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock generator.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_TAIL  = 3'd4
    } spi_state_e;

    // Mode encoding is {cpol, cpha}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int SPI_DEFAULT_DIV = 3;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: o_tick fires on the last cycle of every
// (i_div+1)-cycle window while enabled; i_restart realigns the window.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_restart || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == i_div) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && !i_restart && (r_cnt == i_div);

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master: runtime mode/divisor, LSB-first option,
// multiple chip selects with burst hold, registered outputs throughout.
module spi_master
    import spi_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CS = 1,
    parameter  int DIV_W  = 8,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              t_start,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              hold,
    output logic [WIDTH-1:0]  d_out,
    output logic              busy,
    output logic              done,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int HC_W = $clog2(2 * WIDTH);
    localparam logic [HC_W-1:0] HALF_LAST = HC_W'(2 * WIDTH - 1);

    spi_state_e        r_state, w_next;
    logic              w_tick, w_accept, w_lead;
    logic [WIDTH-1:0]  r_tx, r_rx, r_dout;
    logic [DIV_W-1:0]  r_div;
    logic              r_cpol, r_cpha, r_lsb, r_hold, r_held;
    logic [CS_W-1:0]   r_sel, r_held_sel;
    logic [HC_W-1:0]   r_half;
    logic              r_busy, r_done, r_mosi, r_sck;
    logic [NUM_CS-1:0] r_cs_n;

    function automatic logic [NUM_CS-1:0] cs_dec(input logic [CS_W-1:0] sel);
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (CS_W'(i) == sel) cs_dec[i] = 1'b0;
    endfunction

    function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b,
                                                  input logic lsb);
        return lsb ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
    endfunction

    assign w_accept = (r_state == ST_IDLE) && t_start;
    // Even half-period index ends with the leading SCK edge.
    assign w_lead   = !r_half[0];

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .i_en      (r_state != ST_IDLE),
        .i_restart (w_accept),
        .i_div     (r_div),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (t_start) begin
                    if (r_held && cs_sel == r_held_sel) w_next = ST_SHIFT;
                    else if (r_held)                    w_next = ST_GAP;
                    else                                w_next = ST_SETUP;
                end
            end
            ST_GAP:   if (w_tick) w_next = ST_SETUP;
            ST_SETUP: if (w_tick) w_next = ST_SHIFT;
            ST_SHIFT: if (w_tick && r_half == HALF_LAST) w_next = ST_TAIL;
            ST_TAIL:  if (w_tick) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_dout     <= '0;
            r_div      <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_hold     <= 1'b0;
            r_held     <= 1'b0;
            r_sel      <= '0;
            r_held_sel <= '0;
            r_half     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mosi     <= 1'b0;
            r_sck      <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sck <= cpol;
                    if (t_start) begin
                        r_busy <= 1'b1;
                        r_tx   <= d_in;
                        r_rx   <= '0;
                        r_div  <= clk_div;
                        r_cpol <= cpol;
                        r_cpha <= cpha;
                        r_lsb  <= lsb_first;
                        r_sel  <= cs_sel;
                        r_hold <= hold;
                        r_half <= '0;
                        r_mosi <= 1'b0;
                        r_cs_n <= (w_next == ST_GAP) ? '1 : cs_dec(cs_sel);
                        // CPHA=0 needs the first bit on the wire before the first edge.
                        if (w_next != ST_GAP && !cpha) begin
                            r_mosi <= first_bit(d_in, lsb_first);
                            r_tx   <= shift_out(d_in, lsb_first);
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_cs_n <= cs_dec(r_sel);
                        if (!r_cpha) begin
                            r_mosi <= first_bit(r_tx, r_lsb);
                            r_tx   <= shift_out(r_tx, r_lsb);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_sck  <= ~r_sck;
                        r_half <= r_half + 1'b1;
                        if (w_lead == r_cpha) begin
                            r_mosi <= first_bit(r_tx, r_lsb);
                            r_tx   <= shift_out(r_tx, r_lsb);
                        end else begin
                            r_rx <= shift_in(r_rx, miso, r_lsb);
                        end
                    end
                end
                ST_TAIL: begin
                    if (w_tick) begin
                        r_dout     <= r_rx;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_mosi     <= 1'b0;
                        r_sck      <= r_cpol;
                        r_held     <= r_hold;
                        r_held_sel <= r_sel;
                        if (!r_hold) r_cs_n <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign d_out = r_dout;
    assign busy  = r_busy;
    assign done  = r_done;
    assign mosi  = r_mosi;
    assign sck   = r_sck;
    assign cs_n  = r_cs_n;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: 8-bit/2-CS instance for modes, burst and reset; 16-bit
// instance for LSB-first.
module tb_spi_master;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0, n_fail = 0, n_total = 0;

    // 8-bit, two chip selects
    logic       t_start_a = 1'b0;
    logic [7:0] d_in_a = '0, clk_div_a = '0, d_out_a;
    logic       cpol_a = 1'b0, cpha_a = 1'b0, lsb_a = 1'b0, cs_sel_a = 1'b0, hold_a = 1'b0;
    logic       busy_a, done_a, miso_a, mosi_a, sck_a;
    logic [1:0] cs_n_a;
    logic       loop_a = 1'b0;

    // 16-bit, single chip select
    logic        t_start_b = 1'b0;
    logic [15:0] d_in_b = '0, d_out_b;
    logic [7:0]  clk_div_b = '0;
    logic        lsb_b = 1'b0, cs_sel_b = 1'b0;
    logic        busy_b, done_b, mosi_b, sck_b;
    logic [0:0]  cs_n_b;

    spi_master #(.WIDTH(8), .NUM_CS(2), .DIV_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .t_start(t_start_a), .d_in(d_in_a), .clk_div(clk_div_a),
        .cpol(cpol_a), .cpha(cpha_a), .lsb_first(lsb_a), .cs_sel(cs_sel_a), .hold(hold_a),
        .d_out(d_out_a), .busy(busy_a), .done(done_a), .miso(miso_a), .mosi(mosi_a),
        .sck(sck_a), .cs_n(cs_n_a)
    );

    spi_master #(.WIDTH(16), .NUM_CS(1), .DIV_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .t_start(t_start_b), .d_in(d_in_b), .clk_div(clk_div_b),
        .cpol(1'b0), .cpha(1'b0), .lsb_first(lsb_b), .cs_sel(cs_sel_b), .hold(1'b0),
        .d_out(d_out_b), .busy(busy_b), .done(done_b), .miso(1'b1), .mosi(mosi_b),
        .sck(sck_b), .cs_n(cs_n_b)
    );

    // Device on cs_n_a[0]: returns 0x3C MSB first, captures mosi on its sample edge.
    logic       t_cpol = 1'b0, t_cpha = 1'b0;
    logic [7:0] dev_tx = '0, dev_rx = '0;
    logic       dev_miso = 1'b0, dev_cs_q = 1'b1, dev_sck_q = 1'b0, dev_lead;
    assign miso_a = loop_a ? mosi_a : dev_miso;

    always @(sck_a or cs_n_a[0]) begin
        if (cs_n_a[0] === 1'b0 && dev_cs_q === 1'b1) begin
            dev_tx = 8'h3C;
            dev_rx = 8'h00;
            if (!t_cpha) begin
                dev_miso = dev_tx[7];
                dev_tx   = dev_tx << 1;
            end
        end else if (cs_n_a[0] === 1'b0 && sck_a !== dev_sck_q) begin
            dev_lead = (sck_a !== t_cpol);
            if (dev_lead != t_cpha) begin
                dev_rx = {dev_rx[6:0], mosi_a};
            end else begin
                dev_miso = dev_tx[7];
                dev_tx   = dev_tx << 1;
            end
        end
        dev_cs_q  = cs_n_a[0];
        dev_sck_q = sck_a;
    end

    logic [15:0] b_bits = '0;
    int          b_n = 0;
    always @(posedge sck_b) begin
        if (cs_n_b[0] === 1'b0) begin
            if (b_n < 16) b_bits[b_n] = mosi_b;
            b_n++;
        end
    end

    logic mon0 = 1'b0, mon1 = 1'b0, cs0_bad = 1'b0, cs1_bad = 1'b0;
    int   dn_cnt = 0;
    always @(negedge clk) begin
        if (mon0 && busy_a && cs_n_a[0] !== 1'b0) cs0_bad = 1'b1;
        if (mon1 && cs_n_a[1] !== 1'b0) cs1_bad = 1'b1;
        if (done_a === 1'b1) dn_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [7:0] d, input logic [7:0] div, input logic [1:0] mode,
                           input logic sel, input logic hld);
        @(negedge clk);
        d_in_a = d; clk_div_a = div; cpol_a = mode[1]; cpha_a = mode[0];
        t_cpol = mode[1]; t_cpha = mode[0];
        cs_sel_a = sel; hold_a = hld; lsb_a = 1'b0; t_start_a = 1'b1;
        @(posedge clk);
        #1 t_start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    int          cyc, dn_before;
    logic [1:0]  md;
    logic [7:0]  dv;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", d_out_a, 8'h00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_mosi", mosi_a, 1'b0);
        chk("rst_sck", sck_a, 1'b0);
        chk("rst_cs_n", cs_n_a, 2'b11);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);

        // Mode 0 loopback, H=1
        loop_a = 1'b1; mon0 = 1'b1;
        start_a(8'hA5, 8'd0, SPI_MODE0, 1'b0, 1'b0);
        chk("m0_busy_rise", busy_a, 1'b1);
        wait_done_a(cyc);
        mon0 = 1'b0;
        chk("m0_latency", cyc, 18);
        chk("m0_busy_at_done", busy_a, 1'b0);
        chk("m0_dout", d_out_a, 8'hA5);
        chk("m0_mosi_seq", dev_rx, 8'hA5);
        chk("m0_cs_low", cs0_bad, 1'b0);
        chk("m0_cs_release", cs_n_a, 2'b11);
        @(posedge clk); #1;
        chk("m0_done_pulse", done_a, 1'b0);

        // Modes 1..3 against device model, H=4
        loop_a = 1'b0;
        for (int m = 1; m < 4; m++) begin
            md = m[1:0];
            dv = 8'h51 + 8'(m * 17);
            @(negedge clk) cpol_a = md[1];
            repeat (2) @(posedge clk);
            #1 chk("mode_idle_sck", sck_a, md[1]);
            start_a(dv, 8'd3, md, 1'b0, 1'b0);
            wait_done_a(cyc);
            chk("mode_latency", cyc, 72);
            chk("mode_dout", d_out_a, 8'h3C);
            chk("mode_dev_rx", dev_rx, dv);
            chk("mode_end_sck", sck_a, md[1]);
        end

        // LSB first, 16 bits, miso tied high
        @(negedge clk);
        d_in_b = 16'h8001; lsb_b = 1'b1; clk_div_b = 8'd0; t_start_b = 1'b1;
        @(posedge clk); #1 t_start_b = 1'b0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("lsb_latency", cyc, 34);
        chk("lsb_first_bit", b_bits[0], 1'b1);
        chk("lsb_second_bit", b_bits[1], 1'b0);
        chk("lsb_all_bits", b_bits, 16'h8001);
        chk("lsb_dout", d_out_b, 16'hFFFF);

        // Burst on cs 1, then back-to-back release
        loop_a = 1'b1;
        start_a(8'h12, 8'd0, SPI_MODE0, 1'b1, 1'b1);
        wait_done_a(cyc);
        chk("burst1_latency", cyc, 18);
        chk("burst1_hold_cs", cs_n_a, 2'b01);
        mon1 = 1'b1;
        start_a(8'h34, 8'd0, SPI_MODE0, 1'b1, 1'b0);
        wait_done_a(cyc);
        mon1 = 1'b0;
        chk("burst2_latency", cyc, 17);
        chk("burst2_dout", d_out_a, 8'h34);
        chk("burst_cs1_held", cs1_bad, 1'b0);
        chk("burst2_release", cs_n_a, 2'b11);

        // Switch device while held: GAP of H=2 cycles
        start_a(8'h55, 8'd1, SPI_MODE0, 1'b1, 1'b1);
        wait_done_a(cyc);
        chk("pre_gap_hold", cs_n_a, 2'b01);
        start_a(8'h66, 8'd1, SPI_MODE0, 1'b0, 1'b0);
        chk("gap_cyc0", cs_n_a, 2'b11);
        @(posedge clk); #1;
        chk("gap_cyc1", cs_n_a, 2'b11);
        @(posedge clk); #1;
        chk("gap_setup_cs", cs_n_a, 2'b10);
        wait_done_a(cyc);
        chk("gap_rest_latency", cyc, 36);
        chk("gap_dout", d_out_a, 8'h66);

        // t_start while busy is ignored
        start_a(8'h99, 8'd0, SPI_MODE0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        d_in_a = 8'h11; t_start_a = 1'b1;
        @(negedge clk) t_start_a = 1'b0;
        wait_done_a(cyc);
        chk("ign_dout", d_out_a, 8'h99);
        repeat (2) @(posedge clk);
        #1 chk("ign_no_requeue", busy_a, 1'b0);

        // Reset mid-SHIFT
        start_a(8'hC3, 8'd3, SPI_MODE2, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        dn_before = dn_cnt;
        @(negedge clk) reset = 1'b0;
        #1;
        chk("mid_rst_cs_n", cs_n_a, 2'b11);
        chk("mid_rst_sck", sck_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_mosi", mosi_a, 1'b0);
        chk("mid_rst_dout", d_out_a, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_done", dn_cnt - dn_before, 0);
        chk("mid_rst_idle", busy_a, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised SPI master, the next generation of the team's single-mode 8-bit SPI engine. It adds configurable word width, runtime SPI mode (CPOL/CPHA), LSB-first option, runtime clock divisor, multiple chip selects with burst hold, and a registered done pulse. It sits between the CPU memory-mapped I/O register block and external SPI devices such as flash, SD card and ADCs. One transfer is performed per start request.

## Interface
Parameters:
- WIDTH, 8, bits per transfer (2..32)
- NUM_CS, 1, number of chip-select outputs (1..8)
- DIV_W, 8, width of clk_div input

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- t_start  in  1  start request; sampled only when busy=0
- d_in  in  WIDTH  transmit word, latched on accepted t_start
- clk_div  in  DIV_W  half SCK period H = clk_div+1 clk cycles, latched on accepted t_start
- cpol, cpha, lsb_first  in  1 each  mode controls, latched on accepted t_start
- cs_sel  in  max(1,$clog2(NUM_CS))  target device, latched on accepted t_start
- hold  in  1  keep CS asserted after this transfer (burst), latched on accepted t_start
- d_out  out  WIDTH  received word, updated when done=1
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- miso  in  1  serial in
- mosi  out  1  serial out, driven 0 when not shifting (never Z)
- sck  out  1  SPI clock
- cs_n  out  NUM_CS  active-low chip selects

## Operation
- Reset values: d_out=0, busy=0, done=0, mosi=0, sck=0, cs_n=all 1s, state=IDLE, all counters 0.
- States:
  - IDLE: sck follows the cpol input. On t_start, latch all inputs and set busy=1 next cycle.
    - If CS is already held on the same cs_sel, go to SHIFT.
    - If CS is held on a different cs_sel, go to GAP.
    - Otherwise go to SETUP.
  - GAP: all cs_n=1 for H cycles, then SETUP.
  - SETUP: assert cs_n[cs_sel]=0 for H cycles. For CPHA=0, mosi presents the first bit.
  - SHIFT: 2*WIDTH half-periods, sck toggles at each half-period boundary.
    - CPHA=0: sample miso on the leading edge, update mosi on the trailing edge.
    - CPHA=1: update mosi on the leading edge, sample miso on the trailing edge.
  - TAIL: sck=cpol for H cycles. Then d_out <= shift register, done=1, busy=0, go to IDLE.
    - If hold=0, cs_n returns to all 1s in the same cycle.
    - If hold=1, cs_n[cs_sel] stays 0.
- Bit order: lsb_first=0 shifts MSB first, received bits enter at the LSB. lsb_first=1 mirrors both directions.
- t_start while busy=1 is ignored; there is no queueing.
- Assertion of reset mid-transfer: all outputs take their reset values immediately (cs_n released, sck=0). No done pulse is generated.
- Changes to the latched inputs during busy=1 have no effect.

## Timing
- Accepted t_start at edge k: busy=1 from edge k+1.
- done=1 and busy=0 coincide (2*WIDTH+2)*H cycles after busy rises. The burst path (SETUP skipped) takes (2*WIDTH+1)*H. A GAP adds H.
- Example: WIDTH=8, clk_div=0 gives 18 cycles; clk_div=3 gives 72 cycles.
- A new t_start is accepted in the cycle after done (back-to-back).
- The divider counter wraps from clk_div to 0. clk_div=0 yields SCK = clk/2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE, GAP, SETUP, SHIFT, TAIL)
  - mode constants SPI_MODE0..3
  - a default divisor constant
- Sub-module spi_clk_gen: a DIV_W-bit half-period tick generator with enable and a synchronous restart. Its tick drives all state and edge timing.

## Test plan
- Mode 0, WIDTH=8, clk_div=0, d_in=0xA5, miso looped to mosi:
  - mosi shows 1,0,1,0,0,1,0,1
  - d_out=0xA5
  - done at exactly 18 cycles after busy rises
  - cs_n[0] is 0 for the whole transfer
- Modes 1/2/3, clk_div=3, device model returning 0x3C:
  - d_out=0x3C in each mode
  - sck idle level equals cpol
  - sampling occurs on the correct edge
- lsb_first=1, WIDTH=16, d_in=0x8001, miso tied 1:
  - first mosi bit is 1, second is 0
  - d_out=0xFFFF
- Burst with NUM_CS=2:
  - transfer 1 with hold=1, cs_sel=1, then transfer 2 with hold=0: cs_n[1] stays low across both, and the second transfer takes 17 cycles (clk_div=0, WIDTH=8).
  - transfer with cs_sel=0 while held on cs_sel=1: GAP shows cs_n=2'b11 for H cycles.
- Reset asserted mid-SHIFT, plus t_start pulsed while busy:
  - reset: cs_n=all 1s, sck=0, busy=0 immediately, with no done pulse.
  - t_start during busy: ignored, d_out unchanged.
